channel_scan_mux: RTL and testbench

CHANNEL_SCAN_MUX -- requirements
Module: channel_scan_mux

---
 rtl/channel_scan_mux_if.sv | 29 ++
 rtl/channel_scan_mux.sv | 86 ++++++++
 tb/tb_channel_scan_mux.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/channel_scan_mux_if.sv
// Bus bundle for channel_scan_mux: packed channel inputs, control, registered
// mux output and the per-lane demux copies.
interface channel_scan_mux_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  localparam int SEL_W = $clog2(CH);

  logic [CH*WIDTH-1:0] din;
  logic                mode;
  logic [SEL_W-1:0]    sel;
  logic                en;
  logic [WIDTH-1:0]    dout;
  logic [SEL_W-1:0]    ch_out;
  logic                valid;
  logic                frame_done;
  logic [CH*WIDTH-1:0] demux_out;
  logic [CH-1:0]       demux_valid;

  modport master (
    output din, mode, sel, en,
    input  dout, ch_out, valid, frame_done, demux_out, demux_valid
  );

  modport slave (
    input  din, mode, sel, en,
    output dout, ch_out, valid, frame_done, demux_out, demux_valid
  );
endinterface

// File: rtl/channel_scan_mux.sv
// Channel mux with manual select or auto-scan (DWELL cycles per channel),
// registered output and a demux that keeps the last sample seen on each lane.
module channel_scan_mux #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  channel_scan_mux_if.slave  bus
);
  localparam int SEL_W = $clog2(CH);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       dwell;

  logic [SEL_W-1:0] scan_ch;
  logic [7:0]       scan_dwell;
  logic             dwell_last;
  logic             wrap;
  logic [SEL_W-1:0] cap_ch;
  logic [WIDTH-1:0] cap_data;

  // Entering SCAN starts from channel 0 with a fresh dwell on the same edge,
  // so the effective pointer/counter is zero whenever we are still in MANUAL.
  // NOTE: every always_comb output gets a value on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    scan_ch    = (state == SCAN) ? ptr   : '0;
    scan_dwell = (state == SCAN) ? dwell : '0;
    dwell_last = (scan_dwell == DWELL_LAST);
    wrap       = bus.mode && bus.en && dwell_last && (scan_ch == SEL_W'(CH - 1));
    cap_ch     = bus.mode ? scan_ch : bus.sel;
    cap_data   = bus.din[int'(cap_ch)*WIDTH +: WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= MANUAL;
      ptr             <= '0;
      dwell           <= '0;
      bus.dout        <= '0;
      bus.ch_out      <= '0;
      bus.valid       <= 1'b0;
      bus.frame_done  <= 1'b0;
      // NOTE: the demux lane storage is cleared on reset because its contents
      // are architecturally visible, unlike a scratch memory.
      bus.demux_out   <= '0;
      bus.demux_valid <= '0;
    end else begin
      state           <= bus.mode ? SCAN : MANUAL;
      bus.valid       <= bus.en;
      bus.frame_done  <= wrap;
      bus.demux_valid <= '0;

      if (bus.mode) begin
        if (bus.en && dwell_last) begin
          dwell <= '0;
          ptr   <= scan_ch + SEL_W'(1);
        end else if (bus.en) begin
          dwell <= scan_dwell + 8'd1;
          ptr   <= scan_ch;
        end else begin
          dwell <= scan_dwell;
          ptr   <= scan_ch;
        end
      end else begin
        dwell <= '0;
        ptr   <= '0;
      end

      if (bus.en) begin
        bus.dout                                   <= cap_data;
        bus.ch_out                                 <= cap_ch;
        bus.demux_out[int'(cap_ch)*WIDTH +: WIDTH] <= cap_data;
        bus.demux_valid                            <= CH'(1) << cap_ch;
      end
    end
  end
endmodule

// File: tb/tb_channel_scan_mux.sv
// Self-checking bench: two channel_scan_mux instances (CH=4/DWELL=2 and
// CH=16/DWELL=1) compared cycle by cycle against a slot-count reference model.
module tb_channel_scan_mux;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  channel_scan_mux_if #(.WIDTH(8), .CH(4))  bus_a ();
  channel_scan_mux_if #(.WIDTH(4), .CH(16)) bus_b ();

  channel_scan_mux #(.WIDTH(8), .CH(4), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  channel_scan_mux #(.WIDTH(4), .CH(16), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b. Scan progress is a
  // single slot count in 0..CH*DWELL-1; the channel is slot / DWELL.
  int lane_v [2][16];
  bit m_scan [2];
  int m_slot [2];
  int m_dout [2];
  int m_ch   [2];
  bit m_valid[2];
  bit m_fd   [2];
  int m_dv   [2];
  int m_lane [2][16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int id, input int ch, input int dw, input bit r,
                            input bit mode, input bit en, input int sel);
    int cap;
    if (!r) begin
      m_scan[id] = 0; m_slot[id] = 0; m_dout[id] = 0; m_ch[id] = 0;
      m_valid[id] = 0; m_fd[id] = 0; m_dv[id] = 0;
      for (int k = 0; k < 16; k++) m_lane[id][k] = 0;
      return;
    end
    m_fd[id]    = 0;
    m_dv[id]    = 0;
    m_valid[id] = en;
    if (mode) begin
      if (!m_scan[id]) m_slot[id] = 0;
      cap = m_slot[id] / dw;
      if (en) begin
        m_slot[id]++;
        if (m_slot[id] == ch * dw) begin
          m_slot[id] = 0;
          m_fd[id]   = 1;
        end
      end
    end else begin
      cap = sel;
    end
    m_scan[id] = mode;
    if (en) begin
      m_dout[id]        = lane_v[id][cap];
      m_ch[id]          = cap;
      m_lane[id][cap]   = lane_v[id][cap];
      m_dv[id]          = 1 << cap;
    end
  endtask

  task automatic compare_all();
    logic [63:0] pa, pb;
    pa = '0;
    pb = '0;
    for (int k = 0; k < 4; k++)  pa[k*8 +: 8] = 8'(m_lane[0][k]);
    for (int k = 0; k < 16; k++) pb[k*4 +: 4] = 4'(m_lane[1][k]);
    check("a_dout",        64'(bus_a.dout),        64'(m_dout[0]));
    check("a_ch_out",      64'(bus_a.ch_out),      64'(m_ch[0]));
    check("a_valid",       64'(bus_a.valid),       64'(m_valid[0]));
    check("a_frame_done",  64'(bus_a.frame_done),  64'(m_fd[0]));
    check("a_demux_valid", 64'(bus_a.demux_valid), 64'(m_dv[0]));
    check("a_demux_out",   64'(bus_a.demux_out),   pa);
    check("b_dout",        64'(bus_b.dout),        64'(m_dout[1]));
    check("b_ch_out",      64'(bus_b.ch_out),      64'(m_ch[1]));
    check("b_valid",       64'(bus_b.valid),       64'(m_valid[1]));
    check("b_frame_done",  64'(bus_b.frame_done),  64'(m_fd[1]));
    check("b_demux_valid", 64'(bus_b.demux_valid), 64'(m_dv[1]));
    check("b_demux_out",   64'(bus_b.demux_out),   pb);
  endtask

  task automatic load_din();
    for (int k = 0; k < 4; k++)  bus_a.din[k*8 +: 8] = 8'(lane_v[0][k]);
    for (int k = 0; k < 16; k++) bus_b.din[k*4 +: 4] = 4'(lane_v[1][k]);
  endtask

  // Inputs are stable here (driven 1 time unit after the previous edge).
  task automatic cycle();
    bit r, ma, ea, mb, eb;
    int sa, sb;
    r  = rst_n;
    ma = bus_a.mode; ea = bus_a.en; sa = int'(bus_a.sel);
    mb = bus_b.mode; eb = bus_b.en; sb = int'(bus_b.sel);
    @(posedge clk);
    model_step(0, 4, 2, r, ma, ea, sa);
    model_step(1, 16, 1, r, mb, eb, sb);
    #1;
    compare_all();
  endtask

  task automatic drive_a(input bit mode, input bit en, input int sel);
    bus_a.mode = mode;
    bus_a.en   = en;
    bus_a.sel  = 2'(sel);
  endtask

  task automatic step_a(input bit mode, input bit en, input int sel, input int exp_dout,
                        input string tag);
    drive_a(mode, en, sel);
    cycle();
    if (exp_dout >= 0) check(tag, 64'(bus_a.dout), 64'(exp_dout));
  endtask

  int scan_seq [9] = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h44, 'h44, 'h11};

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      lane_v[0][k] = 0;
      lane_v[1][k] = 0;
    end
    lane_v[0][0] = 'h11; lane_v[0][1] = 'h22; lane_v[0][2] = 'h33; lane_v[0][3] = 'h44;
    load_din();
    drive_a(0, 1, 3);
    bus_b.mode = 1'b1; bus_b.en = 1'b1; bus_b.sel = '0;
    #1;
    cycle();
    cycle();
    check("rst_dout_a",  64'(bus_a.dout),      64'h0);
    check("rst_demux_a", 64'(bus_a.demux_out), 64'h0);

    // Manual select of lane 2, dut_b idle for the directed part.
    rst_n = 1'b1;
    bus_b.mode = 1'b0; bus_b.en = 1'b0;
    step_a(0, 1, 2, 'h33, "manual_dout");
    check("manual_dv",    64'(bus_a.demux_valid),       64'b0100);
    check("manual_lane2", 64'(bus_a.demux_out[23:16]),  64'h33);

    // Nine scan samples from MANUAL; frame_done follows the eighth.
    for (int i = 0; i < 9; i++) begin
      step_a(1, 1, 3, scan_seq[i], "scan_seq");
      check("scan_fd", 64'(bus_a.frame_done), 64'(i == 7));
    end

    // Pause after the first 0x22 sample.
    step_a(0, 0, 0, -1, "idle");
    step_a(1, 1, 0, 'h11, "p_s0");
    step_a(1, 1, 0, 'h11, "p_s1");
    step_a(1, 1, 0, 'h22, "p_s2");
    for (int i = 0; i < 3; i++) begin
      step_a(1, 0, 0, 'h22, "pause_hold");
      check("pause_valid", 64'(bus_a.valid), 64'h0);
    end
    step_a(1, 1, 0, 'h22, "resume_2nd22");
    step_a(1, 1, 0, 'h33, "resume_33");

    // Mode switch mid-dwell, then re-enter scan with a full dwell on ch0.
    step_a(0, 1, 0, 'h11, "sw_manual");
    step_a(1, 1, 2, 'h11, "sw_scan0");
    step_a(1, 1, 2, 'h11, "sw_scan1");
    step_a(1, 1, 2, 'h22, "sw_scan2");
    step_a(1, 1, 2, 'h22, "sw_scan3");
    step_a(1, 1, 2, 'h33, "sw_scan4");
    step_a(1, 1, 2, 'h33, "sw_scan5");
    step_a(1, 1, 2, 'h44, "sw_scan6");

    // Reset while ptr=3, then restart scanning on release.
    rst_n = 1'b0;
    step_a(1, 1, 0, 'h00, "midscan_rst");
    check("midscan_rst_dm", 64'(bus_a.demux_out), 64'h0);
    rst_n = 1'b1;
    step_a(1, 1, 0, 'h11, "rel_first");
    check("rel_ch", 64'(bus_a.ch_out), 64'h0);

    // Manual sweep of all 16 lanes on the wide instance.
    for (int k = 0; k < 16; k++) lane_v[1][k] = $urandom_range(0, 15);
    load_din();
    bus_b.mode = 1'b0; bus_b.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_b.sel = 4'(i);
      cycle();
      check("sweep_dout", 64'(bus_b.dout), 64'(lane_v[1][i]));
    end

    // Randomised traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 4; k++)  lane_v[0][k] = $urandom_range(0, 255);
        for (int k = 0; k < 16; k++) lane_v[1][k] = $urandom_range(0, 15);
        load_din();
      end
      rst_n = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) bus_a.mode = ~bus_a.mode;
      if ($urandom_range(0, 15) == 0) bus_b.mode = ~bus_b.mode;
      bus_a.en  = ($urandom_range(0, 4) != 0);
      bus_b.en  = ($urandom_range(0, 4) != 0);
      bus_a.sel = 2'($urandom_range(0, 3));
      bus_b.sel = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
